// File: rtl/tri_src_arb_if.sv
// Triangle port bundle between two R9 sources, the arbiter and the R10 rasterizer input.
interface tri_src_arb_if #(
  parameter int unsigned SIGFIG = 24,
  parameter int unsigned VERTS  = 3,
  parameter int unsigned AXIS   = 3,
  parameter int unsigned COLORS = 3
);
  localparam int unsigned TRIW = VERTS * AXIS * SIGFIG;
  localparam int unsigned COLW = COLORS * SIGFIG;

  logic            req0_valid_R9H;
  logic [TRIW-1:0] req0_tri_R9S;
  logic [COLW-1:0] req0_color_R9U;
  logic            req0_ack_R9H;
  logic            req1_valid_R9H;
  logic [TRIW-1:0] req1_tri_R9S;
  logic [COLW-1:0] req1_color_R9U;
  logic            req1_ack_R9H;
  logic            halt_RnnnnL;
  logic [TRIW-1:0] tri_R10S;
  logic [COLW-1:0] color_R10U;
  logic            validTri_R10H;
  logic            src_R10H;

  modport slave (
    input  req0_valid_R9H, req0_tri_R9S, req0_color_R9U,
    input  req1_valid_R9H, req1_tri_R9S, req1_color_R9U,
    input  halt_RnnnnL,
    output req0_ack_R9H, req1_ack_R9H,
    output tri_R10S, color_R10U, validTri_R10H, src_R10H
  );

  modport master (
    output req0_valid_R9H, req0_tri_R9S, req0_color_R9U,
    output req1_valid_R9H, req1_tri_R9S, req1_color_R9U,
    output halt_RnnnnL,
    input  req0_ack_R9H, req1_ack_R9H,
    input  tri_R10S, color_R10U, validTri_R10H, src_R10H
  );
endinterface

// File: rtl/tri_src_arb.sv
// Round-robin two-source triangle scheduler with burst limit, enable masks and
// one registered R10 stage; keeps per-source accepted-triangle counts.
module tri_src_arb #(
  parameter int unsigned SIGFIG = 24,
  parameter int unsigned VERTS  = 3,
  parameter int unsigned AXIS   = 3,
  parameter int unsigned COLORS = 3,
  parameter int unsigned BURST  = 4,
  parameter int unsigned CNTW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      en_RnnnnH,
  tri_src_arb_if.slave    bus,
  output logic [CNTW-1:0] cnt0_RnnnnU,
  output logic [CNTW-1:0] cnt1_RnnnnU
);
  localparam int unsigned TRIW = VERTS * AXIS * SIGFIG;
  localparam int unsigned COLW = COLORS * SIGFIG;
  localparam int unsigned BW   = 4;
  localparam logic [BW-1:0] BURST_L = BW'(BURST);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic            valid_q, valid_d;
  logic            src_q, src_d;
  logic [TRIW-1:0] tri_q, tri_d;
  logic [COLW-1:0] color_q, color_d;
  logic [CNTW-1:0] cnt0_q, cnt0_d;
  logic [CNTW-1:0] cnt1_q, cnt1_d;
  logic            r0, r1, gnt0, gnt1;

  // Arbitration FSM; everything is frozen while the rasterizer halts.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    burst_d = burst_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    r0      = bus.req0_valid_R9H & en_RnnnnH[0];
    r1      = bus.req1_valid_R9H & en_RnnnnH[1];
    if (bus.halt_RnnnnL) begin
      unique case (state_q)
        IDLE: begin
          // With both requesting, the source that did not own last wins.
          if (r0 && (!r1 || last_q)) begin
            gnt0    = 1'b1;
            state_d = OWN0;
            burst_d = BW'(1);
          end else if (r1) begin
            gnt1    = 1'b1;
            state_d = OWN1;
            burst_d = BW'(1);
          end
        end
        OWN0: begin
          if (r0 && ((burst_q < BURST_L) || !r1)) begin
            gnt0    = 1'b1;
            burst_d = (burst_q < BURST_L) ? BW'(burst_q + BW'(1)) : burst_q;
          end else if (r1) begin
            gnt1    = 1'b1;
            state_d = OWN1;
            burst_d = BW'(1);
            last_d  = 1'b0;
          end else begin
            state_d = IDLE;
            last_d  = 1'b0;
          end
        end
        OWN1: begin
          if (r1 && ((burst_q < BURST_L) || !r0)) begin
            gnt1    = 1'b1;
            burst_d = (burst_q < BURST_L) ? BW'(burst_q + BW'(1)) : burst_q;
          end else if (r0) begin
            gnt0    = 1'b1;
            state_d = OWN0;
            burst_d = BW'(1);
            last_d  = 1'b1;
          end else begin
            state_d = IDLE;
            last_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // R10 stage and counters: load on a grant, drop valid on an idle unhalted cycle.
  always_comb begin
    valid_d = valid_q;
    src_d   = src_q;
    tri_d   = tri_q;
    color_d = color_q;
    cnt0_d  = cnt0_q + CNTW'(gnt0);
    cnt1_d  = cnt1_q + CNTW'(gnt1);
    if (gnt0) begin
      valid_d = 1'b1;
      src_d   = 1'b0;
      tri_d   = bus.req0_tri_R9S;
      color_d = bus.req0_color_R9U;
    end else if (gnt1) begin
      valid_d = 1'b1;
      src_d   = 1'b1;
      tri_d   = bus.req1_tri_R9S;
      color_d = bus.req1_color_R9U;
    end else if (bus.halt_RnnnnL) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      burst_q <= '0;
      valid_q <= 1'b0;
      src_q   <= 1'b0;
      tri_q   <= '0;
      color_q <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      tri_q   <= tri_d;
      color_q <= color_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  // Acks are same-cycle so the source can advance; they read 0 during reset.
  assign bus.req0_ack_R9H  = gnt0 & rst;
  assign bus.req1_ack_R9H  = gnt1 & rst;
  assign bus.validTri_R10H = valid_q;
  assign bus.src_R10H      = src_q;
  assign bus.tri_R10S      = tri_q;
  assign bus.color_R10U    = color_q;
  assign cnt0_RnnnnU       = cnt0_q;
  assign cnt1_RnnnnU       = cnt1_q;
endmodule

// File: tb/tb_tri_src_arb.sv
// Self-checking bench for tri_src_arb: ack vector table, hand sequences and an
// R10 output scoreboard fed from the bench's own source model.
module tb_tri_src_arb;
  localparam int unsigned SIGFIG = 24;
  localparam int unsigned VERTS  = 3;
  localparam int unsigned AXIS   = 3;
  localparam int unsigned COLORS = 3;
  localparam int unsigned TRIW   = VERTS * AXIS * SIGFIG;
  localparam int unsigned COLW   = COLORS * SIGFIG;

  typedef struct packed {
    logic            src;
    logic [TRIW-1:0] t;
    logic [COLW-1:0] c;
  } exp_t;

  typedef struct {
    logic [1:0] en;
    bit v0, v1, h, a0, a1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  en, en_w;
  logic [31:0] cnt0, cnt1;
  logic [3:0]  wcnt0, wcnt1;

  tri_src_arb_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) bus ();
  tri_src_arb_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) wbus ();

  tri_src_arb #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS),
                .BURST(4), .CNTW(32)) dut (
    .clk(clk), .rst(rst), .en_RnnnnH(en), .bus(bus),
    .cnt0_RnnnnU(cnt0), .cnt1_RnnnnU(cnt1));

  tri_src_arb #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS),
                .BURST(4), .CNTW(4)) dut_w (
    .clk(clk), .rst(rst), .en_RnnnnH(en_w), .bus(wbus),
    .cnt0_RnnnnU(wcnt0), .cnt1_RnnnnU(wcnt1));

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb[$];
  exp_t        e;
  bit          e_valid;
  bit          sact[2];
  int          sleft[2];
  logic [23:0] sx[2];
  vec_t        tbl[$];

  function automatic logic [TRIW-1:0] mk_tri(input bit s, input logic [23:0] x);
    logic [23:0] k;
    k = s ? 24'h5A5A5A : 24'h123456;
    return {{8{x ^ k}}, x};
  endfunction

  function automatic logic [COLW-1:0] mk_col(input bit s, input logic [23:0] x);
    logic [23:0] k;
    k = s ? 24'hC0FFEE : 24'hBEEF00;
    return {x + 24'h000111, ~x, k};
  endfunction

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply();
    bus.req0_valid_R9H = sact[0];
    bus.req0_tri_R9S   = mk_tri(1'b0, sx[0]);
    bus.req0_color_R9U = mk_col(1'b0, sx[0]);
    bus.req1_valid_R9H = sact[1];
    bus.req1_tri_R9S   = mk_tri(1'b1, sx[1]);
    bus.req1_color_R9U = mk_col(1'b1, sx[1]);
  endtask

  // One clock: check R10 against the model, log acks, then advance model and sources.
  task automatic tick(output bit a0, output bit a1);
    bit h;
    @(negedge clk);
    check("r10_valid", bus.validTri_R10H, e_valid);
    check("r10_src", bus.src_R10H, e.src);
    check("r10_tri", bus.tri_R10S, e.t);
    check("r10_color", bus.color_R10U, e.c);
    a0 = bus.req0_ack_R9H;
    a1 = bus.req1_ack_R9H;
    if (a0 && a1) check("ack_exclusive", 2'b11, 2'b00);
    if (a0) sb.push_back('{1'b0, mk_tri(1'b0, sx[0]), mk_col(1'b0, sx[0])});
    if (a1) sb.push_back('{1'b1, mk_tri(1'b1, sx[1]), mk_col(1'b1, sx[1])});
    h = bus.halt_RnnnnL;
    @(posedge clk);
    #1;
    if (a0 || a1) begin
      e       = sb.pop_front();
      e_valid = 1'b1;
    end else if (h) begin
      e_valid = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if ((i == 0 && a0) || (i == 1 && a1)) begin
        sx[i] = sx[i] + 24'd1;
        if (sleft[i] > 0) begin
          sleft[i]--;
          if (sleft[i] == 0) sact[i] = 1'b0;
        end
      end
    end
    apply();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_valid", bus.validTri_R10H, 1'b0);
    check("rst_src", bus.src_R10H, 1'b0);
    check("rst_tri", bus.tri_R10S, '0);
    check("rst_color", bus.color_R10U, '0);
    check("rst_cnt0", cnt0, 32'd0);
    check("rst_cnt1", cnt1, 32'd0);
    check("rst_ack0", bus.req0_ack_R9H, 1'b0);
    check("rst_ack1", bus.req1_ack_R9H, 1'b0);
    e_valid = 1'b0;
    e       = '0;
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a0, a1;
    int n, first, last, s0, s1;
    rst = 1'b1;
    en = 2'b11;
    en_w = 2'b00;
    bus.halt_RnnnnL = 1'b1;
    wbus.halt_RnnnnL = 1'b1;
    wbus.req0_valid_R9H = 1'b0;
    wbus.req0_tri_R9S = '0;
    wbus.req0_color_R9U = '0;
    wbus.req1_valid_R9H = 1'b0;
    wbus.req1_tri_R9S = mk_tri(1'b1, 24'h00ABCD);
    wbus.req1_color_R9U = mk_col(1'b1, 24'h00ABCD);
    sact = '{1'b0, 1'b0};
    sleft = '{-1, -1};
    sx = '{24'h000100, 24'h800100};
    apply();
    do_reset();

    // Reset mid-stream with 7 triangles accepted and R10 valid.
    sleft[0] = 7;
    sact[0] = 1'b1;
    apply();
    n = 0;
    for (int k = 0; k < 20 && n < 7; k++) begin
      tick(a0, a1);
      if (a0) n++;
    end
    check("mid_acks", 32'(n), 32'd7);
    check("mid_cnt0", cnt0, 32'd7);
    check("mid_valid", bus.validTri_R10H, 1'b1);
    #2;
    do_reset();
    sact = '{1'b1, 1'b1};
    sleft = '{-1, -1};
    apply();
    tick(a0, a1);
    check("post_rst_first_grant", {a1, a0}, 2'b01);
    tick(a0, a1);

    // Single source, 10 back-to-back triangles.
    sact = '{1'b0, 1'b0};
    apply();
    do_reset();
    sx[0] = 24'h000400;
    sleft[0] = 10;
    sact[0] = 1'b1;
    apply();
    n = 0;
    first = -1;
    last = -1;
    for (int k = 0; k < 30 && n < 10; k++) begin
      tick(a0, a1);
      if (a0) begin
        n++;
        if (first < 0) first = k;
        last = k;
      end
    end
    check("single_acks", 32'(n), 32'd10);
    check("single_back_to_back", 32'(last - first), 32'd9);
    tick(a0, a1);
    tick(a0, a1);
    check("single_cnt0", cnt0, 32'd10);
    check("single_cnt1", cnt1, 32'd0);

    // Contention, both always valid: bursts of 4.
    do_reset();
    sact = '{1'b1, 1'b1};
    sleft = '{-1, -1};
    apply();
    for (int k = 0; k < 16; k++) begin
      tick(a0, a1);
      check($sformatf("cont_grant%0d", k), {a1, a0}, ((k / 4) % 2 == 0) ? 2'b01 : 2'b10);
    end
    check("cont_cnt0", cnt0, 32'd8);
    check("cont_cnt1", cnt1, 32'd8);
    sact = '{1'b0, 1'b0};
    apply();
    tick(a0, a1);

    // Vector table: halt mid-burst, masks, idle and re-arbitration.
    tbl.push_back('{2'b11, 1, 1, 1, 1, 0});
    tbl.push_back('{2'b11, 1, 1, 1, 1, 0});
    repeat (5) tbl.push_back('{2'b11, 1, 1, 0, 0, 0});
    tbl.push_back('{2'b11, 1, 1, 1, 1, 0});
    tbl.push_back('{2'b11, 1, 1, 1, 1, 0});
    tbl.push_back('{2'b11, 1, 1, 1, 0, 1});
    tbl.push_back('{2'b11, 1, 0, 1, 1, 0});
    tbl.push_back('{2'b01, 1, 1, 1, 1, 0});
    tbl.push_back('{2'b01, 1, 1, 1, 1, 0});
    tbl.push_back('{2'b01, 1, 1, 1, 1, 0});
    tbl.push_back('{2'b01, 1, 1, 1, 1, 0});
    tbl.push_back('{2'b10, 1, 1, 1, 0, 1});
    tbl.push_back('{2'b11, 0, 0, 1, 0, 0});
    tbl.push_back('{2'b11, 0, 1, 1, 0, 1});
    tbl.push_back('{2'b11, 1, 1, 1, 0, 1});
    tbl.push_back('{2'b00, 1, 1, 1, 0, 0});
    tbl.push_back('{2'b11, 1, 1, 1, 1, 0});
    tbl.push_back('{2'b11, 1, 1, 0, 0, 0});
    tbl.push_back('{2'b11, 0, 1, 1, 0, 1});
    do_reset();
    s0 = 0;
    s1 = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en;
      bus.halt_RnnnnL = tbl[i].h;
      sact[0] = tbl[i].v0;
      sact[1] = tbl[i].v1;
      apply();
      tick(a0, a1);
      check($sformatf("row%0d_acks", i), {a1, a0}, {tbl[i].a1, tbl[i].a0});
      s0 += int'(tbl[i].a0);
      s1 += int'(tbl[i].a1);
    end
    en = 2'b11;
    bus.halt_RnnnnL = 1'b1;
    sact = '{1'b0, 1'b0};
    apply();
    tick(a0, a1);
    tick(a0, a1);
    check("tbl_cnt0", cnt0, 32'(s0));
    check("tbl_cnt1", cnt1, 32'(s1));

    // 4-bit counter wraps after 17 source-1 accepts.
    en_w = 2'b10;
    wbus.req1_valid_R9H = 1'b1;
    n = 0;
    for (int k = 0; k < 40 && n < 17; k++) begin
      @(negedge clk);
      if (wbus.req1_ack_R9H) n++;
      @(posedge clk);
      #1;
    end
    wbus.req1_valid_R9H = 1'b0;
    check("wrap_acks", 32'(n), 32'd17);
    check("wrap_cnt1", wcnt1, 4'd1);
    check("wrap_cnt0", wcnt0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tri_src_arb.md
Name: tri_src_arb

Overview:
- Two-requester triangle scheduler in front of the rasterizer's R10 input (bbox stage).
- Shares the single triangle port between two triangle sources, e.g. two driver streams or two geometry units.
- Arbitration is round-robin with a programmable burst limit and per-source enable masks.
- Output is one registered stage that obeys the rasterizer's `halt_RnnnnL` backpressure and keeps per-source accepted-triangle counts for the performance monitor.

Parameters:
- SIGFIG, 24, bits in color and position
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex
- COLORS, 3, color channels
- BURST, 4, maximum consecutive grants to one source while the other is requesting (legal range 1..15)
- CNTW, 32, width of the per-source accepted-triangle counters

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low (0 = reset)
- `en_RnnnnH`  in  2  quasi-static source enable mask; bit i = 0 masks source i
- `req0_valid_R9H`  in  1  source 0 has a triangle
- `req0_tri_R9S`  in  VERTS*AXIS*SIGFIG  source 0 position, signed, packed vertex-major
- `req0_color_R9U`  in  COLORS*SIGFIG  source 0 color
- `req0_ack_R9H`  out  1  source 0 triangle accepted this cycle
- `req1_valid_R9H`, `req1_tri_R9S`, `req1_color_R9U`, `req1_ack_R9H`: same as source 0, for source 1
- `halt_RnnnnL`  in  1  from rasterizer; 0 = stall, hold R10 outputs
- `tri_R10S`  out  VERTS*AXIS*SIGFIG  triangle to rasterizer
- `color_R10U`  out  COLORS*SIGFIG  color to rasterizer
- `validTri_R10H`  out  1  R10 triangle valid
- `src_R10H`  out  1  source index of the current R10 triangle
- `cnt0_RnnnnU`, `cnt1_RnnnnU`  out  CNTW  accepted-triangle counters

Behaviour:
- Reset (`rst` = 0, asynchronous):
  - All R10 outputs, both acks and both counters clear to 0.
  - State = IDLE, `last` = 1 so that source 0 wins first, `burst_cnt` = 0.
- Effective request: `r_i` = `req_i_valid_R9H` & `en_RnnnnH[i]`.
- Handshake:
  - A source holds valid and data stable until it sees ack = 1 combinationally in the same cycle.
  - On the cycle after the ack, the source may present a new triangle.
  - `ack_i` = grant_i & `halt_RnnnnL`. Acks are mutually exclusive.
- Latency: a triangle acked in cycle N appears on `tri_R10S`/`color_R10U` with `validTri_R10H` = 1 in cycle N+1.
- `halt_RnnnnL` = 0:
  - No acks.
  - R10 outputs, `src_R10H`, state, `last`, `burst_cnt` and counters all frozen.
- `halt_RnnnnL` = 1, no `r_i`: `validTri_R10H` <= 0; data registers hold; state moves to IDLE.
- FSM states: IDLE, OWN0, OWN1. These apply only when `halt_RnnnnL` = 1.
  - IDLE:
    - Both `r_i` → grant the source != `last`.
    - One `r_i` → grant that source.
    - On a grant: go to OWNi, `burst_cnt` = 1.
  - OWNi, `r_i` and (`burst_cnt` < BURST or !`r_other`): grant i; `burst_cnt` = min(`burst_cnt` + 1, BURST), saturating.
  - OWNi, `r_other` and (`burst_cnt` == BURST or !`r_i`): grant other; go to OWNother; `burst_cnt` = 1; `last` = i.
  - OWNi, neither requesting: go to IDLE; `last` = i.
- Counters: `cnt_i` increments on each `ack_i`; wraps modulo 2^CNTW with no flag.
- Mask changes take effect next cycle:
  - If the owner becomes masked, the other source is granted immediately when it is requesting.
  - A triangle already acked is never dropped.
- BURST = 1 gives strict alternation under contention.
- Data path is pass-through with no arithmetic; field order is preserved bit-exact.

Test Plan:
- Reset mid-stream: assert `rst` = 0 while `validTri_R10H` = 1 and `cnt0_RnnnnU` = 7 → outputs and counters read 0 asynchronously, before the next `clk` edge. After release, the first contended grant goes to source 0.
- Single source, no halt: source 0 presents 10 back-to-back triangles (x0 = 0x000400, +1 each) → 10 consecutive `validTri_R10H` cycles starting 1 cycle after the first ack, data in order, `cnt0_RnnnnU` = 10, `cnt1_RnnnnU` = 0.
- Contention, BURST = 4, both sources always valid: grant sequence 0,0,0,0,1,1,1,1,0,… → after 16 accepts, `cnt0_RnnnnU` = `cnt1_RnnnnU` = 8; `src_R10H` toggles every 4 valid cycles.
- Backpressure: hold `halt_RnnnnL` = 0 for 5 cycles mid-burst → no acks, R10 outputs unchanged for 5 cycles. The burst resumes with `burst_cnt` preserved: e.g. paused after 2 grants, then 2 more grants before switching.
- Mask: `en_RnnnnH` = 2'b01 with both valid → only source 0 acked, `cnt1_RnnnnU` stays 0. Switching to 2'b10 while in OWN0 → the next grant is source 1 the following cycle.
- Counter wrap: CNTW = 4, 17 source-1 accepts → `cnt1_RnnnnU` = 1.
